// File: rtl/v68k_bus_pkg.sv
// v68k_bus_pkg: shared size/status codes, FSM states and default DTACK timeout.
package v68k_bus_pkg;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_WORD = 2'd1, SZ_LONG = 2'd2} size_e;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_BUS_ERR = 2'd1, ST_ADDR_ERR = 2'd2} status_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_TERM} state_e;
  function automatic size_e norm_size(input logic [1:0] s);
    return s == 2'd3 ? SZ_WORD : size_e'(s);
  endfunction
endpackage

// File: rtl/v68k_bus_controller_timeout.sv
// bus_timeout_counter: reloadable down-counter flagging the last permitted WAIT cycle.
module bus_timeout_counter #(
  parameter int N = 64
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK)
    if (RESET) cnt <= '0;
    else if (clr) cnt <= W'(N - 1);
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign expired = en && cnt == '0;
endmodule

// File: rtl/v68k_bus_controller.sv
// v68k_bus_controller: runs byte/word/long core requests as 68000-style AS/UDS/LDS/DTACK bus cycles.
module v68k_bus_controller
  import v68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [23:0] req_addr,
  input  logic [2:0]  req_fc,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] rdata,
  output logic [22:0] A,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  input  logic [15:0] D_in,
  output logic [15:0] D_out,
  output logic        D_oe,
  input  logic        DTACK,
  input  logic        BERR,
  input  logic        HALT,
  output logic [2:0]  FC
);
  state_e state, ns;
  status_e st_n;
  size_e lat_sz, sz_n;
  logic lat_rw, rw_l_n, lat_a0, a0_n, first, first_n, cont, cont_n, acc, expired, bus, ds;
  logic as_n, uds_n, lds_n, rw_n, doe_n, done_n;
  logic [15:0] wdata, wdata_n, dout_n;
  logic [22:0] a_n;
  logic [2:0] fc_n;
  logic [31:0] rdata_n;
  logic [1:0] status_n;

  assign req_ready = state == S_IDLE && !HALT && !RESET;
  assign acc = req && req_ready;
  assign st_n = state == S_IDLE ? ST_ADDR_ERR : (BERR || !DTACK) ? ST_BUS_ERR : ST_OK;

  bus_timeout_counter #(.N(TIMEOUT_CYCLES)) u_timeout (
    .CLK(CLK), .RESET(RESET), .clr(state == S_STROBE), .en(state == S_WAIT), .expired(expired)
  );

  always_ff @(posedge CLK)
    if (RESET) begin
      state <= S_IDLE;
      lat_rw <= 1'b1;
      lat_sz <= SZ_BYTE;
      lat_a0 <= 1'b0;
      first <= 1'b0;
      cont <= 1'b0;
      wdata <= '0;
      A <= '0;
      FC <= '0;
      D_out <= '0;
      AS <= 1'b0;
      UDS <= 1'b0;
      LDS <= 1'b0;
      RW <= 1'b1;
      D_oe <= 1'b0;
      done <= 1'b0;
      status <= ST_OK;
      rdata <= '0;
    end else begin
      state <= ns;
      lat_rw <= rw_l_n;
      lat_sz <= sz_n;
      lat_a0 <= a0_n;
      first <= first_n;
      cont <= cont_n;
      wdata <= wdata_n;
      A <= a_n;
      FC <= fc_n;
      D_out <= dout_n;
      AS <= as_n;
      UDS <= uds_n;
      LDS <= lds_n;
      RW <= rw_n;
      D_oe <= doe_n;
      done <= done_n;
      status <= status_n;
      rdata <= rdata_n;
    end

  always_comb begin
    ns = state;
    case (state)
      S_IDLE:   ns = !acc ? S_IDLE : (norm_size(req_size) != SZ_BYTE && req_addr[0]) ? S_TERM : S_ADDR;
      S_ADDR:   ns = S_STROBE;
      S_STROBE: ns = S_WAIT;
      S_WAIT:   ns = (BERR || DTACK || expired) ? S_TERM : S_WAIT;
      S_TERM:   ns = cont ? S_ADDR : S_IDLE;
      default:  ns = S_IDLE;
    endcase
  end

  // Output registers load from the next state so the pins line up with the state they belong to.
  always_comb begin
    rw_l_n = lat_rw;
    sz_n = lat_sz;
    a0_n = lat_a0;
    first_n = first;
    cont_n = cont;
    wdata_n = wdata;
    a_n = A;
    fc_n = FC;
    dout_n = D_out;
    rdata_n = rdata;
    status_n = status;
    done_n = 1'b0;
    if (acc) begin
      rw_l_n = req_rw;
      sz_n = norm_size(req_size);
      a0_n = req_addr[0];
      first_n = 1'b1;
      wdata_n = req_wdata[15:0];
      a_n = req_addr[23:1];
      fc_n = req_fc;
      rdata_n = '0;
      dout_n = sz_n == SZ_BYTE ? {2{req_wdata[7:0]}} : sz_n == SZ_LONG ? req_wdata[31:16] : req_wdata[15:0];
    end
    if (state == S_TERM && cont) begin
      a_n = A + 23'd1;
      first_n = 1'b0;
      dout_n = wdata;
    end
    if (ns == S_TERM) begin
      cont_n = state == S_WAIT && lat_sz == SZ_LONG && first && st_n == ST_OK;
      done_n = !cont_n;
      status_n = cont_n ? status : st_n;
    end
    if (state == S_WAIT && DTACK && !BERR && lat_rw)
      rdata_n = lat_sz == SZ_BYTE ? {24'd0, lat_a0 ? D_in[7:0] : D_in[15:8]} :
                (lat_sz == SZ_LONG && first) ? {D_in, rdata[15:0]} : {rdata[31:16], D_in};
    bus = (ns inside {S_ADDR, S_STROBE, S_WAIT}) || (ns == S_TERM && state == S_WAIT);
    as_n = ns inside {S_STROBE, S_WAIT};
    ds = rw_l_n ? as_n : ns == S_WAIT;
    uds_n = ds && (sz_n != SZ_BYTE || !a0_n);
    lds_n = ds && (sz_n != SZ_BYTE || a0_n);
    rw_n = bus ? rw_l_n : 1'b1;
    doe_n = bus && !rw_l_n;
  end
endmodule

// File: tb/tb_v68k_bus_controller.sv
// tb_v68k_bus_controller: randomized and directed transactions against a transaction-level model.
module tb_v68k_bus_controller;
  logic CLK = 0, RESET = 1, req = 0, req_rw = 1, DTACK = 0, BERR = 0, HALT = 0;
  logic [1:0] req_size = 0;
  logic [23:0] req_addr = 0;
  logic [2:0] req_fc = 0;
  logic [31:0] req_wdata = 0;
  logic [15:0] D_in = 0;
  logic req_ready, done, AS, UDS, LDS, RW, D_oe;
  logic [1:0] status;
  logic [31:0] rdata;
  logic [22:0] A;
  logic [15:0] D_out;
  logic [2:0] FC;
  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  v68k_bus_controller #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_addr(req_addr), .req_fc(req_fc), .req_wdata(req_wdata),
    .done(done), .status(status), .rdata(rdata), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS),
    .RW(RW), .D_in(D_in), .D_out(D_out), .D_oe(D_oe), .DTACK(DTACK), .BERR(BERR),
    .HALT(HALT), .FC(FC)
  );

  task automatic run_txn(input logic rw, input logic [1:0] sz, input logic [23:0] addr,
                         input logic [2:0] fc, input logic [31:0] wd, input int w0, input int w1,
                         input logic b0, input logic b1, input logic dt_with_b,
                         input logic [15:0] d0, input logic [15:0] d1, input logic halt_mid);
    int w[2], n, as_cnt, bi, bj, exp_nb, exp_lat;
    logic bb[2], got_done, mis, resp, doe_term;
    logic [15:0] din[2], exp_dout[2];
    logic [1:0] nsz, exp_st, lanes;
    logic [31:0] exp_rd;
    logic [22:0] oa[2];
    logic orw[2], odoe[2];
    logic [2:0] ofc[2];
    logic [1:0] ods1[2], ods2[2];
    logic [15:0] odout[2];
    w[0] = w0; w[1] = w1; bb[0] = b0; bb[1] = b1; din[0] = d0; din[1] = d1;
    nsz = sz == 2'd3 ? 2'd1 : sz;
    mis = nsz != 2'd0 && addr[0];
    lanes = nsz != 2'd0 ? 2'b11 : addr[0] ? 2'b01 : 2'b10;
    exp_dout[0] = nsz == 2'd0 ? {wd[7:0], wd[7:0]} : nsz == 2'd2 ? wd[31:16] : wd[15:0];
    exp_dout[1] = wd[15:0];
    exp_rd = nsz == 2'd0 ? {24'd0, addr[0] ? d0[7:0] : d0[15:8]} : nsz == 2'd2 ? {d0, d1} : {16'd0, d0};
    exp_nb = 0; exp_lat = 1; exp_st = 2'd2;
    if (!mis) begin
      exp_lat = 0; exp_st = 2'd0;
      for (int h = 0; h < (nsz == 2'd2 ? 2 : 1); h++) begin
        exp_nb++;
        if (w[h] >= 64) begin exp_lat += 67; exp_st = 2'd1; break; end
        exp_lat += 4 + w[h];
        if (bb[h]) begin exp_st = 2'd1; break; end
      end
    end
    @(negedge CLK);
    req = 1; req_rw = rw; req_size = sz; req_addr = addr; req_fc = fc; req_wdata = wd;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
    @(negedge CLK);
    req = 0; n = 1; as_cnt = 0; bi = -1; got_done = 0; doe_term = 0;
    while (n <= 300) begin
      if (halt_mid && n == 2) HALT = 1;
      as_cnt = AS ? as_cnt + 1 : 0;
      if (as_cnt == 1) begin
        bi++;
        if (bi < 2) begin oa[bi] = A; orw[bi] = RW; ofc[bi] = FC; ods1[bi] = {UDS, LDS}; odout[bi] = D_out; odoe[bi] = D_oe; end
      end
      bj = bi < 0 ? 0 : bi > 1 ? 1 : bi;
      if (as_cnt == 2) ods2[bj] = {UDS, LDS};
      resp = as_cnt >= 2 && bi >= 0 && bi < 2 && as_cnt - 1 == w[bj] + 1;
      DTACK = resp && (!bb[bj] || dt_with_b);
      BERR = resp && bb[bj];
      D_in = din[bj];
      if (done) begin got_done = 1; doe_term = D_oe; break; end
      @(negedge CLK); n++;
    end
    DTACK = 0; BERR = 0;
    checks++; if (!got_done) begin failures++; $display("FAIL done_seen: got no done in %0d cycles want done", n); end
    checks++; if (n !== exp_lat) begin failures++; $display("FAIL latency: got %0d want %0d", n, exp_lat); end
    checks++; if (status !== exp_st) begin failures++; $display("FAIL status: got %0d want %0d", status, exp_st); end
    checks++; if (bi + 1 !== exp_nb) begin failures++; $display("FAIL bus_cycles: got %0d want %0d", bi + 1, exp_nb); end
    for (int h = 0; h < exp_nb && h <= bi && h < 2; h++) begin
      checks++; if (oa[h] !== addr[23:1] + 23'(h)) begin failures++; $display("FAIL addr%0d: got %h want %h", h, oa[h], addr[23:1] + 23'(h)); end
      checks++; if (orw[h] !== rw || ofc[h] !== fc) begin failures++; $display("FAIL rw_fc%0d: got %b/%0d want %b/%0d", h, orw[h], ofc[h], rw, fc); end
      checks++; if (ods1[h] !== (rw ? lanes : 2'b00) || ods2[h] !== lanes) begin
        failures++; $display("FAIL lanes%0d: got %b,%b want %b,%b", h, ods1[h], ods2[h], rw ? lanes : 2'b00, lanes); end
      if (!rw) begin
        checks++; if (odout[h] !== exp_dout[h] || odoe[h] !== 1'b1) begin
          failures++; $display("FAIL wdata%0d: got %h oe=%b want %h oe=1", h, odout[h], odoe[h], exp_dout[h]); end
      end
    end
    if (rw && exp_st == 2'd0) begin
      checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL rdata: got %h want %h", rdata, exp_rd); end
    end
    if (rw && nsz == 2'd2 && exp_st == 2'd1 && exp_nb == 1) begin
      checks++; if (rdata[15:0] !== 16'd0) begin failures++; $display("FAIL rdata_lo_fail: got %h want 0000", rdata[15:0]); end
    end
    if (!mis) begin
      checks++; if (doe_term !== !rw) begin failures++; $display("FAIL doe_term: got %b want %b", doe_term, !rw); end
    end
    @(negedge CLK);
    checks++; if (done !== 1'b0 || req_ready !== !HALT || D_oe !== 1'b0 || AS !== 1'b0) begin
      failures++; $display("FAIL after_done: got done=%b rdy=%b oe=%b as=%b want 0,%b,0,0", done, req_ready, D_oe, AS, !HALT); end
    HALT = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(negedge CLK);
    checks++; if ({AS, UDS, LDS, RW, D_oe} !== 5'b00010) begin failures++; $display("FAIL reset_strobes: got %b want 00010", {AS, UDS, LDS, RW, D_oe}); end
    checks++; if (A !== 0 || FC !== 0 || D_out !== 0) begin failures++; $display("FAIL reset_bus: got %h %h %h want 0 0 0", A, FC, D_out); end
    checks++; if (done !== 0 || status !== 0 || rdata !== 0) begin failures++; $display("FAIL reset_result: got %b %0d %h want 0 0 0", done, status, rdata); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    RESET = 0;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    run_txn(1, 2'd1, 24'h000100, 3'd5, 0, 0, 0, 0, 0, 0, 16'hBEEF, 0, 0);
    run_txn(0, 2'd0, 24'h000201, 3'd1, 32'h000000A5, 2, 0, 0, 0, 0, 0, 0, 0);
    run_txn(1, 2'd2, 24'h000400, 3'd6, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h5678, 0);
    run_txn(1, 2'd1, 24'h000003, 3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_txn(0, 2'd2, 24'h000003, 3'd2, 32'h11112222, 0, 0, 0, 0, 0, 0, 0, 0);
    run_txn(1, 2'd0, 24'h000011, 3'd1, 0, 1, 0, 0, 0, 0, 16'hC3D4, 0, 0);
    run_txn(1, 2'd3, 24'h000ABC, 3'd1, 0, 0, 0, 0, 0, 0, 16'h4242, 0, 0);
  endtask

  task automatic test_berr_long_write();
    run_txn(0, 2'd2, 24'h000800, 3'd5, 32'hCAFEF00D, 0, 0, 1, 0, 1, 0, 0, 0);
    run_txn(1, 2'd2, 24'h000900, 3'd5, 0, 1, 0, 1, 0, 0, 16'h9999, 0, 0);
  endtask

  task automatic test_timeout();
    run_txn(1, 2'd1, 24'h000500, 3'd1, 0, 999, 0, 0, 0, 0, 16'h7777, 0, 0);
    run_txn(1, 2'd1, 24'h000502, 3'd1, 0, 63, 0, 0, 0, 0, 16'h6363, 0, 0);
  endtask

  task automatic test_halt();
    HALT = 1;
    @(negedge CLK);
    req = 1; req_rw = 1; req_size = 2'd1; req_addr = 24'h000600; req_fc = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (req_ready !== 1'b0 || AS !== 1'b0) begin failures++; $display("FAIL halt_gate: got rdy=%b as=%b want 0 0", req_ready, AS); end
    end
    req = 0; HALT = 0;
    run_txn(0, 2'd1, 24'h000600, 3'd1, 32'h0000ABCD, 1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge CLK);
    req = 1; req_rw = 1; req_size = 2'd1; req_addr = 24'h000700; req_fc = 3'd2;
    @(negedge CLK);
    req = 0; n = 0;
    while (!AS && n < 10) begin @(negedge CLK); n++; end
    checks++; if (!AS) begin failures++; $display("FAIL mid_as: got no AS want AS"); end
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    checks++; if ({AS, UDS, LDS, D_oe, RW, done, req_ready} !== 7'b0000100) begin
      failures++; $display("FAIL mid_reset: got %b want 0000100", {AS, UDS, LDS, D_oe, RW, done, req_ready}); end
    RESET = 0;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1 || AS !== 1'b0) begin failures++; $display("FAIL mid_idle: got rdy=%b as=%b want 1 0", req_ready, AS); end
    run_txn(1, 2'd1, 24'h000700, 3'd2, 0, 0, 0, 0, 0, 0, 16'h0F0F, 0, 0);
  endtask

  task automatic test_random();
    logic [1:0] sz;
    logic [23:0] addr;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      addr = 24'($urandom);
      if (sz != 2'd0 && $urandom_range(0, 7) != 0) addr[0] = 1'b0;
      run_txn(1'($urandom), sz, addr, 3'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
              16'($urandom), 16'($urandom), $urandom_range(0, 4) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_berr_long_write();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
